psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum_pkg.sv | 18 +
 rtl/psum_sat_add.sv | 28 ++
 rtl/psum_accum.sv | 147 ++++++++++++++
 tb/tb_psum_accum.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types and saturation bounds for the partial-sum accumulator.
package psum_accum_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Bounds are returned wide; callers truncate to their own psum width.
    function automatic logic signed [63:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One column adder: signed add that either clamps or wraps on overflow.
module psum_sat_add
    import psum_accum_pkg::*;
#(
    parameter int bw  = 20,
    parameter int sat = 1
) (
    input  logic signed [bw-1:0] a,
    input  logic signed [bw-1:0] b,
    output logic signed [bw-1:0] y
);

    localparam logic signed [bw-1:0] max_val = bw'(sat_max(bw));
    localparam logic signed [bw-1:0] min_val = bw'(sat_min(bw));

    logic [bw:0] sum;

    assign sum = {a[bw-1], a} + {b[bw-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        y = sum[bw-1:0];
        if (sat != 0 && sum[bw] != sum[bw-1]) begin
            y = sum[bw] ? min_val : max_val;
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum scratch memory: overwrite/accumulate with a one-entry forwarding
// stage, registered reads, and a depth-cycle zeroing sweep after reset or on request.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int bw_psum = 20,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int sat     = 1,
    localparam int aw     = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [aw-1:0]          wr_add,
    input  logic                   rd,
    input  logic [aw-1:0]          rd_add,
    output logic [col*bw_psum-1:0] out,
    output logic                   out_valid,
    input  logic                   clear_start,
    output logic                   busy
);

    localparam int ww = col * bw_psum;

    state_t         state;
    state_t         state_next;
    logic [aw-1:0]  ptr;

    logic [ww-1:0]  mem [depth];

    logic           stg_valid;
    logic [aw-1:0]  stg_addr;
    logic [ww-1:0]  stg_data;

    logic           accept;
    logic           rd_accept;
    logic           wr_ok;
    logic           rd_ok;
    logic           stg_ok;
    logic [ww-1:0]  old_word;
    logic [ww-1:0]  sum_word;
    logic [ww-1:0]  new_word;
    logic [ww-1:0]  rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= (state == CLEAR && ptr != aw'(depth - 1)) ? ptr + aw'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (ptr == aw'(depth - 1)) state_next = RUN;
            RUN:     if (clear_start) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == CLEAR);
    end

    assign accept    = in_valid & in_ready;
    assign rd_accept = rd & in_ready;
    assign wr_ok     = int'(wr_add) < depth;
    assign rd_ok     = int'(rd_add) < depth;
    assign stg_ok    = int'(stg_addr) < depth;

    // The stage holds the post-op word, so chained accumulates see it as the old value.
    always_comb begin
        old_word = '0;
        if (stg_valid && stg_addr == wr_add) begin
            old_word = stg_data;
        end else if (wr_ok) begin
            old_word = mem[wr_add];
        end
    end

    always_comb begin
        rd_word = '0;
        if (stg_valid && stg_addr == rd_add) begin
            rd_word = stg_data;
        end else if (rd_ok) begin
            rd_word = mem[rd_add];
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_sat_add #(
            .bw  (bw_psum),
            .sat (sat)
        ) u_add (
            .a (old_word[c*bw_psum +: bw_psum]),
            .b (in[c*bw_psum +: bw_psum]),
            .y (sum_word[c*bw_psum +: bw_psum])
        );
    end

    assign new_word = mode ? sum_word : in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_addr <= wr_add;
                stg_data <= new_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_accept;
            if (rd_accept) begin
                out <= rd_word;
            end
        end
    end

    // Sweep write comes last so it wins over a stage commit to the same word.
    always_ff @(posedge clk) begin
        if (stg_valid && stg_ok) begin
            mem[stg_addr] <= stg_data;
        end
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench: saturating and wrapping instances driven in lockstep against a behavioural scoreboard.
module tb_psum_accum;

    localparam int BW    = 20;
    localparam int COL   = 8;
    localparam int DEPTH = 16;
    localparam int WW    = BW * COL;
    localparam int PMAX  = 524287;
    localparam int PMIN  = -524288;

    logic          clk = 1'b0;
    logic          reset;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          mode;
    logic [3:0]    wr_add;
    logic          rd;
    logic [3:0]    rd_add;
    logic          clear_start;

    logic          in_ready_s, out_valid_s, busy_s;
    logic          in_ready_w, out_valid_w, busy_w;
    logic [WW-1:0] out_s, out_w;

    typedef struct {
        logic [WW-1:0] exp_s;
        logic [WW-1:0] exp_w;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      model_s [DEPTH][COL];
    int      model_w [DEPTH][COL];
    int      busy_left;
    int      pass_cnt  = 0;
    int      check_cnt = 0;

    always #5 clk = ~clk;

    psum_accum #(.bw_psum(BW), .col(COL), .depth(DEPTH), .sat(1)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .in          (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_s),
        .mode        (mode),
        .wr_add      (wr_add),
        .rd          (rd),
        .rd_add      (rd_add),
        .out         (out_s),
        .out_valid   (out_valid_s),
        .clear_start (clear_start),
        .busy        (busy_s)
    );

    psum_accum #(.bw_psum(BW), .col(COL), .depth(DEPTH), .sat(0)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .in          (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_w),
        .mode        (mode),
        .wr_add      (wr_add),
        .rd          (rd),
        .rd_add      (rd_add),
        .out         (out_w),
        .out_valid   (out_valid_w),
        .clear_start (clear_start),
        .busy        (busy_w)
    );

    task automatic check_output(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int sx(input logic [BW-1:0] v);
        logic signed [BW-1:0] s;
        s = v;
        return int'(s);
    endfunction

    function automatic logic [WW-1:0] make_word(input int base, input int step);
        logic [WW-1:0] w;
        for (int c = 0; c < COL; c++) w[c*BW +: BW] = BW'(base + c * step);
        return w;
    endfunction

    function automatic logic [WW-1:0] model_word(input bit use_sat, input int a);
        logic [WW-1:0] w;
        for (int c = 0; c < COL; c++) w[c*BW +: BW] = BW'(use_sat ? model_s[a][c] : model_w[a][c]);
        return w;
    endfunction

    function automatic void model_zero();
        for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < COL; c++) begin
                model_s[a][c] = 0;
                model_w[a][c] = 0;
            end
    endfunction

    task automatic apply_stimulus(input logic v, input logic m, input logic [3:0] wa,
                                  input logic [WW-1:0] d, input logic r, input logic [3:0] ra,
                                  input logic cs);
        logic b;
        int   inv;
        int   s;
        b = (busy_left > 0);
        check_output("busy_ready", {busy_w, busy_s, in_ready_w, in_ready_s}, {b, b, ~b, ~b});
        in_valid    = v;
        mode        = m;
        wr_add      = wa;
        in_data     = d;
        rd          = r;
        rd_add      = ra;
        clear_start = cs;
        if (busy_left == 0) begin
            if (r) sb.push_back('{model_word(1, int'(ra)), model_word(0, int'(ra))});
            if (v) begin
                for (int c = 0; c < COL; c++) begin
                    inv = sx(d[c*BW +: BW]);
                    if (m) begin
                        s = model_s[wa][c] + inv;
                        model_s[wa][c] = (s > PMAX) ? PMAX : (s < PMIN) ? PMIN : s;
                        model_w[wa][c] = sx(BW'(model_w[wa][c] + inv));
                    end else begin
                        model_s[wa][c] = inv;
                        model_w[wa][c] = inv;
                    end
                end
            end
            if (cs) begin
                busy_left = DEPTH;
                model_zero();
            end
        end else begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        rd          = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 4'd0, '0, 0, 4'd0, 0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        rd          = 1'b0;
        clear_start = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset_out", {out_w, out_s}, '0);
        check_output("reset_flags", {out_valid_w, out_valid_s, busy_w, busy_s, in_ready_w, in_ready_s}, 6'b001100);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        busy_left = DEPTH;
        model_zero();
        sb.delete();
    endtask

    // Every out_valid must match the oldest outstanding read expectation.
    always @(negedge clk) begin
        rd_exp_t e;
        if (!reset && (out_valid_s || out_valid_w)) begin
            if (sb.size() == 0) begin
                check_output("unexpected_out_valid", {out_valid_w, out_valid_s}, '0);
            end else begin
                e = sb.pop_front();
                check_output("out_valid", {out_valid_w, out_valid_s}, 2'b11);
                check_output("out_sat", out_s, e.exp_s);
                check_output("out_wrap", out_w, e.exp_w);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        mode        = 1'b0;
        wr_add      = '0;
        rd          = 1'b0;
        rd_add      = '0;
        clear_start = 1'b0;
        busy_left   = DEPTH;
        model_zero();
        #1;

        // Reset, sweep of exactly DEPTH cycles, then every word reads zero.
        do_reset();
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) apply_stimulus(0, 0, 4'd0, '0, 1, 4'(a), 0);

        // Overwrite then accumulate on the next cycle, read forwarded and committed.
        apply_stimulus(1, 0, 4'd3, make_word(100, 0), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd3, make_word(25, 0), 0, 4'd0, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd3, 0);
        idle(2);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd3, 0);

        // Four back-to-back +1 accumulates; the last one also reads pre-op value.
        apply_stimulus(1, 1, 4'd5, make_word(1, 0), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd5, make_word(1, 0), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd5, make_word(1, 0), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd5, make_word(1, 0), 1, 4'd5, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd5, 0);

        // Columns accumulate independently.
        apply_stimulus(1, 0, 4'd7, make_word(-1000, 333), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd7, make_word(50, -71), 0, 4'd0, 0);
        idle(1);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd7, 0);

        // Saturation versus wrap at both ends of the range.
        apply_stimulus(1, 0, 4'd0, make_word(PMAX, 0), 0, 4'd0, 0);
        apply_stimulus(1, 1, 4'd0, make_word(1, 0), 0, 4'd0, 0);
        apply_stimulus(1, 0, 4'd1, make_word(-1, 0), 1, 4'd0, 0);
        apply_stimulus(1, 1, 4'd1, make_word(PMIN, 0), 0, 4'd0, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd1, 0);

        // Clear sweep with an op and read landing on the clear_start cycle.
        apply_stimulus(1, 0, 4'd2, make_word(77, 0), 0, 4'd0, 0);
        apply_stimulus(1, 0, 4'd9, make_word(5, 3), 1, 4'd2, 0);
        apply_stimulus(1, 0, 4'd4, make_word(99, 0), 1, 4'd9, 1);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 1, 4'd2, make_word(1, 0), 1, 4'd2, 1);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd2, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd9, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd4, 0);
        idle(2);

        // Reset with an op staged, then again in the middle of the sweep.
        apply_stimulus(1, 0, 4'd6, make_word(55, 0), 0, 4'd0, 0);
        do_reset();
        idle(7);
        do_reset();
        idle(DEPTH);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd6, 0);
        apply_stimulus(1, 1, 4'd8, make_word(-7, 2), 0, 4'd0, 0);
        apply_stimulus(0, 0, 4'd0, '0, 1, 4'd8, 0);

        for (int i = 0; i < 6 && sb.size() != 0; i++) idle(1);
        check_output("scoreboard_drained", WW'(sb.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
